sprite_engine: RTL

- Parametrised multi-sprite renderer for the VGA pixel pipeline.
- Replaces single-sprite rendering with N_SPRITES independently positioned channels and per-channel enable.
- Adds vsync-synchronised (shadowed) configuration, frame-counter animation, fixed-priority compositing and a sticky sprite-collision flag.
- Sits between the VGA timing generator (pixel coordinates) and the final pixel mux; the background is drawn wherever visible_out = 0.

---
 rtl/sprite_pkg.sv | 21 ++
 rtl/sprite_channel.sv | 110 +++++++++++
 rtl/sprite_engine.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types, widths and colour decode for the multi-sprite renderer.
package sprite_pkg;

  localparam int COORD_W = 10;
  localparam int COLOR_W = 6;
  localparam int RGB_W   = 24;

  // Per-channel placement and enable, written through the shadow set.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               en;
  } spr_cfg_t;

  // 6-bit rrggbb colour index to 24-bit RGB; each 2-bit field is
  // replicated so 2'b11 maps to full intensity 8'hFF.
  function automatic logic [RGB_W-1:0] color_decode(input logic [COLOR_W-1:0] idx);
    color_decode = {{4{idx[5:4]}}, {4{idx[3:2]}}, {4{idx[1:0]}}};
  endfunction

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: shadow/active configuration, window test,
// texel addressing, texture ROM and the stage-1 pipeline registers.
module sprite_channel
  import sprite_pkg::*;
#(
  parameter int                 CH     = 0,
  parameter int                 SPR_W  = 64,
  parameter int                 SPR_H  = 64,
  parameter int                 FW     = 1,
  parameter logic [COLOR_W-1:0] TRANSP = 6'h00
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_i,
  input  logic               load_i,
  input  spr_cfg_t           wr_cfg_i,
  input  logic [COORD_W-1:0] px_i,
  input  logic [COORD_W-1:0] py_i,
  input  logic [FW-1:0]      frame_i,
  output logic               in_win_o,
  output logic [COLOR_W-1:0] color_o
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  localparam int AW = FW + YW + XW;
  localparam logic [COORD_W:0] W_EXT = SPR_W[COORD_W:0];
  localparam logic [COORD_W:0] H_EXT = SPR_H[COORD_W:0];

  spr_cfg_t           shadow_q, shadow_d;
  spr_cfg_t           active_q, active_d;
  logic [COORD_W:0]   x_end_s, y_end_s;
  logic               in_win_s, in_win_q;
  logic [XW-1:0]      rx_s;
  logic [YW-1:0]      ry_s;
  logic [AW-1:0]      addr_s;
  logic [COLOR_W-1:0] color_q;

  // Texture contents: the centre column is transparent so every sprite
  // has see-through texels; elsewhere a non-zero pattern that varies
  // with row, column, channel and animation frame.
  function automatic logic [COLOR_W-1:0] texel(input logic [AW-1:0] a);
    int rx, ry, f, s;
    rx = int'(a[XW-1:0]);
    ry = int'(a[XW +: YW]);
    f  = int'(a[XW+YW +: FW]);
    s  = ((ry * 7 + rx * 3 + CH * 11 + f * 29 + 25) % 63) + 1;
    if (rx == SPR_W / 2) begin
      texel = TRANSP;
    end else begin
      texel = COLOR_W'(s);
    end
  endfunction

  // Shadow takes host writes; active loads at frame start, with a write
  // in that same cycle bypassing straight into the active set.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_i) begin
      shadow_d = wr_cfg_i;
    end else begin
      shadow_d = shadow_q;
    end
    if (load_i) begin
      active_d = shadow_d;
    end else begin
      active_d = active_q;
    end
  end

  // Configuration registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // Window test in 11 bits so sprites past the right/bottom edge clip
  // instead of wrapping; texel address is frame, row offset, column offset.
  always_comb begin
    x_end_s  = {1'b0, active_q.x} + W_EXT;
    y_end_s  = {1'b0, active_q.y} + H_EXT;
    in_win_s = active_q.en
             & (px_i >= active_q.x) & ({1'b0, px_i} < x_end_s)
             & (py_i >= active_q.y) & ({1'b0, py_i} < y_end_s);
    rx_s     = XW'(px_i - active_q.x);
    ry_s     = YW'(py_i - active_q.y);
    addr_s   = {frame_i, ry_s, rx_s};
  end

  // Synchronous ROM read with the window flag carried alongside.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_win_q <= 1'b0;
      color_q  <= 6'h00;
    end else begin
      in_win_q <= in_win_s;
      color_q  <= texel(addr_s);
    end
  end

  assign in_win_o = in_win_q;
  assign color_o  = color_q;

endmodule

// File: rtl/sprite_engine.sv
// Multi-sprite renderer: animation counter, per-channel pipelines,
// fixed-priority compositing (channel 0 on top) and sticky collision.
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int                 N_SPRITES = 4,
  parameter int                 SPR_W     = 64,
  parameter int                 SPR_H     = 64,
  parameter int                 N_FRAMES  = 2,
  parameter int                 ANIM_DIV  = 8,
  parameter logic [COLOR_W-1:0] TRANSP    = 6'h00,
  localparam int                IW        = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1,
  localparam int                FW        = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               pixel_valid,
  input  logic               frame_start,
  input  logic               cfg_we,
  input  logic [IW-1:0]      cfg_idx,
  input  logic [COORD_W-1:0] cfg_x,
  input  logic [COORD_W-1:0] cfg_y,
  input  logic               cfg_en,
  output logic [RGB_W-1:0]   rgb_out,
  output logic               visible_out,
  output logic [IW-1:0]      hit_id,
  output logic               valid_out,
  output logic               collision
);

  logic [7:0]           div_q, div_d;
  logic [FW-1:0]        anim_q, anim_d;
  spr_cfg_t             wr_cfg_s;
  logic [N_SPRITES-1:0] in_win_s;
  logic [COLOR_W-1:0]   color_s [N_SPRITES];
  logic [N_SPRITES-1:0] opaque_s;
  logic                 valid_q;
  logic [RGB_W-1:0]     rgb_d, rgb_q;
  logic [IW-1:0]        hit_d, hit_q;
  logic                 vis_d, vis_q;
  logic                 vout_q;
  logic [7:0]           cnt_s;
  logic                 coll_d, coll_q;

  assign wr_cfg_s = {cfg_x, cfg_y, cfg_en};

  // Animation advances one frame every ANIM_DIV frame starts.
  always_comb begin
    div_d  = div_q;
    anim_d = anim_q;
    if (frame_start) begin
      if (div_q == 8'(ANIM_DIV - 1)) begin
        div_d  = 8'd0;
        anim_d = FW'((int'(anim_q) + 1) % N_FRAMES);
      end else begin
        div_d  = div_q + 8'd1;
        anim_d = anim_q;
      end
    end else begin
      div_d  = div_q;
      anim_d = anim_q;
    end
  end

  // Animation state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= 8'd0;
      anim_q <= '0;
    end else begin
      div_q  <= div_d;
      anim_q <= anim_d;
    end
  end

  for (genvar g = 0; g < N_SPRITES; g++) begin : g_ch
    sprite_channel #(
      .CH     (g),
      .SPR_W  (SPR_W),
      .SPR_H  (SPR_H),
      .FW     (FW),
      .TRANSP (TRANSP)
    ) u_ch (
      .clk_i    (clk),
      .rst_i    (rst),
      .wr_i     (cfg_we && (cfg_idx == IW'(g))),
      .load_i   (frame_start),
      .wr_cfg_i (wr_cfg_s),
      .px_i     (pixel_x),
      .py_i     (pixel_y),
      .frame_i  (anim_q),
      .in_win_o (in_win_s[g]),
      .color_o  (color_s[g])
    );
  end

  // Priority compositing: scanning from the highest index down lets the
  // lowest opaque channel win; also counts opaque channels for collision.
  always_comb begin
    opaque_s = '0;
    rgb_d    = 24'd0;
    hit_d    = '0;
    cnt_s    = 8'd0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      opaque_s[i] = in_win_s[i] & valid_q & (color_s[i] != TRANSP);
      hit_d       = opaque_s[i] ? IW'(i) : hit_d;
      rgb_d       = opaque_s[i] ? color_decode(color_s[i]) : rgb_d;
      cnt_s       = cnt_s + 8'(opaque_s[i]);
    end
    vis_d  = |opaque_s;
    coll_d = (cnt_s >= 8'd2) | (coll_q & ~frame_start);
  end

  // Stage-1 valid and registered stage-2 outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      rgb_q   <= 24'd0;
      hit_q   <= '0;
      vis_q   <= 1'b0;
      vout_q  <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      valid_q <= pixel_valid;
      rgb_q   <= rgb_d;
      hit_q   <= hit_d;
      vis_q   <= vis_d;
      vout_q  <= valid_q;
      coll_q  <= coll_d;
    end
  end

  assign rgb_out     = rgb_q;
  assign visible_out = vis_q;
  assign hit_id      = hit_q;
  assign valid_out   = vout_q;
  assign collision   = coll_q;

endmodule
